// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a UART sender: grants one
// requester, holds its character and send_flag for one frame, then a guard gap.
module uart_tx_arbiter #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLK_PARIOD = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] data0,
  input  logic [6:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       send_flag,
  output logic [6:0] send_data,
  output logic       busy
);

  localparam int BIT_CYCLES   = (1000000000 / BAUD_RATE) / CLK_PARIOD;
  localparam int FRAME_CYCLES = 11 * BIT_CYCLES;
  localparam int GAP_CYCLES   = BIT_CYCLES;
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t      state_reg, state_next;
  logic [15:0] count_reg, count_next;
  // last_grant also identifies the current owner while a frame is in flight
  logic        last_grant_reg, last_grant_next;
  logic [6:0]  send_data_reg, send_data_next;
  logic        send_flag_reg, send_flag_next;
  logic        gnt0_reg, gnt0_next;
  logic        gnt1_reg, gnt1_next;
  logic        done0_reg, done0_next;
  logic        done1_reg, done1_next;
  logic        pick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      last_grant_reg <= 1'b1;
      send_data_reg  <= '0;
      send_flag_reg  <= 1'b0;
      gnt0_reg       <= 1'b0;
      gnt1_reg       <= 1'b0;
      done0_reg      <= 1'b0;
      done1_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      last_grant_reg <= last_grant_next;
      send_data_reg  <= send_data_next;
      send_flag_reg  <= send_flag_next;
      gnt0_reg       <= gnt0_next;
      gnt1_reg       <= gnt1_next;
      done0_reg      <= done0_next;
      done1_reg      <= done1_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    last_grant_next = last_grant_reg;
    send_data_next  = send_data_reg;
    send_flag_next  = send_flag_reg;
    gnt0_next       = 1'b0;
    gnt1_next       = 1'b0;
    done0_next      = 1'b0;
    done1_next      = 1'b0;
    pick            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          // on a tie the requester not served last time wins
          pick            = (req0 && req1) ? ~last_grant_reg : req1;
          state_next      = SEND;
          count_next      = '0;
          last_grant_next = pick;
          send_data_next  = pick ? data1 : data0;
          send_flag_next  = 1'b1;
          gnt0_next       = ~pick;
          gnt1_next       = pick;
        end
      end
      SEND: begin
        if (count_reg == FRAME_LAST) begin
          state_next     = GAP;
          count_next     = '0;
          send_flag_next = 1'b0;
          done0_next     = ~last_grant_reg;
          done1_next     = last_grant_reg;
        end else begin
          count_next = count_reg + 16'd1;
        end
      end
      GAP: begin
        if (count_reg == GAP_LAST) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count_reg + 16'd1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign gnt0      = gnt0_reg;
  assign gnt1      = gnt1_reg;
  assign done0     = done0_reg;
  assign done1     = done1_reg;
  assign send_flag = send_flag_reg;
  assign send_data = send_data_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a timeline model (grant cycle plus offsets) predicts
// every output each cycle; scenario tasks compare and check ordering.
module tb_uart_tx_arbiter;
  localparam int FRAME = 110;
  localparam int GAP   = 10;
  localparam int SPACE = FRAME + GAP + 1;

  logic       clk = 1'b0;
  logic       rst_n, req0, req1, gnt0, gnt1, done0, done1, send_flag, busy;
  logic [6:0] data0, data1, send_data;

  uart_tx_arbiter #(.BAUD_RATE(100000), .CLK_PARIOD(1000)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .send_flag(send_flag), .send_data(send_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  // model: most recent grant edge, its owner and captured character
  bit       m_active = 0;
  int       m_g = 0;
  bit       m_owner = 0;
  bit       m_last = 1;
  bit [6:0] m_data = 0;
  logic [12:0] exp_vec, obs;

  task automatic step(input logic r, input logic a0, input logic a1,
                      input logic [6:0] x0, input logic [6:0] x1);
    int d;
    rst_n = r; req0 = a0; req1 = a1; data0 = x0; data1 = x1;
    @(posedge clk);
    cyc++;
    if (!r) begin
      m_active = 0; m_last = 1; m_data = 0;
    end else if ((!m_active || cyc >= m_g + SPACE) && (a0 || a1)) begin
      m_owner  = (a0 && a1) ? !m_last : a1;
      m_last   = m_owner;
      m_g      = cyc;
      m_data   = m_owner ? x1 : x0;
      m_active = 1;
    end
    #1;
    exp_vec = {6'b0, m_data};
    if (m_active) begin
      d = cyc - m_g;
      exp_vec[12] = (d == 0) && !m_owner;
      exp_vec[11] = (d == 0) && m_owner;
      exp_vec[10] = (d == FRAME) && !m_owner;
      exp_vec[9]  = (d == FRAME) && m_owner;
      exp_vec[8]  = (d < FRAME);
      exp_vec[7]  = (d < FRAME + GAP);
    end
    obs = {gnt0, gnt1, done0, done1, send_flag, busy, send_data};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'($urandom), 1'($urandom), 7'($urandom), 7'($urandom));
      checks++;
      if (obs !== 13'h0) begin
        errors++; $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, obs, 13'h0);
      end
    end
  endtask

  task automatic test_single();
    int g = -1;
    step(1'b1, 1'b1, 1'b0, 7'h41, 7'h12);
    g = cyc;
    for (int i = 0; i < 125; i++) begin
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL single cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      step(1'b1, 1'b0, 1'b0, 7'($urandom), 7'($urandom));
    end
    checks++;
    if (busy !== 1'b0 || send_data !== 7'h41) begin
      errors++; $display("FAIL single_end busy=%b data=%h exp busy=0 data=41 g=%0d", busy, send_data, g);
    end
  endtask

  task automatic test_tie();
    int g0 = -1, g1 = -1, both = 0;
    step(1'b0, 1'b0, 1'b0, 7'h0, 7'h0);
    for (int i = 0; i < 250; i++) begin
      step(1'b1, 1'b1, 1'b1, 7'h33, 7'h55);
      if (gnt0 === 1'b1 && g0 < 0) g0 = cyc;
      if (gnt1 === 1'b1 && g1 < 0) g1 = cyc;
      if (gnt0 === 1'b1 && gnt1 === 1'b1) both++;
      if (gnt1 === 1'b1) begin
        checks++;
        if (send_data !== 7'h55) begin
          errors++; $display("FAIL tie_data got=%h exp=55", send_data);
        end
      end
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL tie cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
    checks++;
    if (g0 < 0 || g1 - g0 !== SPACE || both !== 0) begin
      errors++; $display("FAIL tie_spacing got=%0d exp=%0d (g0=%0d both=%0d)", g1 - g0, SPACE, g0, both);
    end
  endtask

  task automatic test_fairness();
    int gq[$], dq[$];
    int exp_order[4] = '{0, 1, 0, 1};
    step(1'b0, 1'b0, 1'b0, 7'h0, 7'h0);
    for (int i = 0; i < 4 * SPACE; i++) begin
      step(1'b1, 1'b1, 1'b1, 7'($urandom), 7'($urandom));
      if (gnt0 === 1'b1) gq.push_back(0);
      if (gnt1 === 1'b1) gq.push_back(1);
      if (done0 === 1'b1) dq.push_back(0);
      if (done1 === 1'b1) dq.push_back(1);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL fair cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
    checks++;
    if (gq.size() !== 4 || dq.size() !== 4) begin
      errors++; $display("FAIL fair_count grants=%0d dones=%0d exp 4/4", gq.size(), dq.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gq[k] !== exp_order[k] || dq[k] !== exp_order[k]) begin
          errors++; $display("FAIL fair_order idx=%0d gnt=%0d done=%0d exp=%0d", k, gq[k], dq[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_late_and_stable();
    int n1 = 0;
    step(1'b0, 1'b0, 1'b0, 7'h0, 7'h0);
    step(1'b1, 1'b1, 1'b0, 7'h7F, 7'h0);
    for (int i = 1; i < 130; i++) begin
      step(1'b1, 1'b0, (i == 30), (i >= 5) ? 7'h00 : 7'h7F, 7'($urandom));
      if (gnt1 === 1'b1) n1++;
      if (i <= 109) begin
        checks++;
        if (send_data !== 7'h7F) begin
          errors++; $display("FAIL stable cyc=%0d got=%h exp=7f", cyc, send_data);
        end
      end
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL late cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
    checks++;
    if (n1 !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL late_req gnt1_count=%0d busy=%b exp 0/0", n1, busy);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b0, 1'b0, 1'b0, 7'h0, 7'h0);
    step(1'b1, 1'b1, 1'b0, 7'h2A, 7'h0);
    for (int i = 1; i < 180; i++) begin
      if (i == 50)       step(1'b0, 1'b0, 1'b0, 7'h2A, 7'h0);
      else if (i == 140) step(1'b1, 1'b1, 1'b0, 7'h19, 7'h0);
      else               step(1'b1, 1'b0, 1'b0, 7'h2A, 7'h0);
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL midreset cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
      if (i == 50 || i == 140) begin
        checks++;
        if ((i == 50 && obs !== 13'h0) || (i == 140 && (gnt0 !== 1'b1 || send_data !== 7'h19))) begin
          errors++; $display("FAIL midreset_edge i=%0d got=%h", i, obs);
        end
      end
    end
  endtask

  task automatic test_random();
    step(1'b0, 1'b0, 1'b0, 7'h0, 7'h0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 399) != 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0), 7'($urandom), 7'($urandom));
      checks++;
      if (obs !== exp_vec) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_late_and_stable();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter BAUD_RATE, default 9600, meaning the serial bit rate in bit/s.
REQ-002 The block SHALL have parameter CLK_PARIOD, default 50, meaning the clock period in ns.
REQ-003 The block SHALL derive localparam BIT_CYCLES = (1000000000/BAUD_RATE)/CLK_PARIOD, FRAME_CYCLES = 11*BIT_CYCLES and GAP_CYCLES = BIT_CYCLES.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have ports req0 and req1, input, 1 bit each: level transmit request from requester 0 and requester 1.
REQ-007 The block SHALL have ports data0 and data1, input, 7 bits each: the character offered by each requester.
REQ-008 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle pulse, request accepted and data captured.
REQ-009 The block SHALL have ports done0 and done1, output, 1 bit each: one-cycle pulse, the owner's frame time has elapsed.
REQ-010 The block SHALL have port send_flag, output, 1 bit: the enable driven to the serial sender.
REQ-011 The block SHALL have port send_data, output, 7 bits: the character driven to the serial sender.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, SEND and GAP.
REQ-014 Requests SHALL be sampled only in IDLE; req inputs in SEND or GAP SHALL have no effect.
REQ-015 In IDLE with exactly one req high at a clock edge, that requester SHALL be granted at that edge.
REQ-016 In IDLE with both req high, the requester not recorded in last_grant SHALL be granted (round-robin).
REQ-017 On grant at edge T, from T: state = SEND, gntN = 1 for one cycle, owner = N, last_grant = N, send_data = dataN as sampled at T, send_flag = 1.
REQ-018 send_data SHALL hold the captured value until the next grant, regardless of changes to data0 or data1.
REQ-019 send_flag SHALL stay high for exactly FRAME_CYCLES cycles, counted by a 16-bit cycle counter.
REQ-020 At edge T+FRAME_CYCLES: send_flag = 0, doneN = 1 for one cycle for the owner, state = GAP, counter cleared.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles, then the state SHALL return to IDLE.
REQ-022 Minimum grant-to-grant spacing SHALL be FRAME_CYCLES + GAP_CYCLES + 1 cycles.
REQ-023 gnt0/gnt1 SHALL never be high in the same cycle, and likewise done0/done1.
REQ-024 A req dropped before being sampled in IDLE SHALL produce no grant.
REQ-025 A req held high after its grant SHALL be treated as a new request at the next IDLE, subject to round-robin.
REQ-026 The counter SHALL saturate-free count to FRAME_CYCLES-1 and never wrap; the FRAME_CYCLES > 65535 configuration is unsupported.

Reset
REQ-027 While rst_n = 0 at a clock edge: state = IDLE, counter = 0, last_grant = 1 (so req0 wins the first tie).
REQ-028 While rst_n = 0 at a clock edge, all outputs SHALL be 0: send_flag, send_data, gnt0, gnt1, done0, done1 and busy.
REQ-029 Reset asserted in SEND or GAP SHALL abort the frame with no done pulse; send_flag SHALL be 0 from that edge.

Verification (CLK_PARIOD = 1000, BAUD_RATE = 100000 -> BIT_CYCLES = 10, FRAME_CYCLES = 110, GAP_CYCLES = 10)
REQ-030 Single request: req0 = 1, data0 = 7'h41 at edge T -> gnt0 at T; send_flag high for 110 cycles with send_data = 7'h41; done0 at T+110; busy low at T+120.
REQ-031 Tie after reset: req0 = req1 = 1, data1 = 7'h55 -> gnt0 first; gnt1 at the next IDLE, 121 cycles later, with send_data = 7'h55; no cycle with both gnt high.
REQ-032 Fairness: both req held high for 4 frames -> grant order 0,1,0,1 and done order 0,1,0,1.
REQ-033 Late request: req1 pulsed for 1 cycle during SEND -> no gnt1; busy returns low after GAP.
REQ-034 Data stability: data0 changed to 7'h00 at T+5 after a grant with 7'h7F -> send_data stays 7'h7F through T+109.
REQ-035 Mid-frame reset: rst_n = 0 at T+50 -> send_flag, busy and send_data 0 from T+50, no done0; a new req0 after release is granted normally.
